// File: rtl/hazard_unit_if.sv
// hazard_unit_if: decode-to-hazard-unit bundle.
// The decode side (master) presents the per-instruction decode; the hazard
// unit (slave) returns the stall, the forwarding selects and the status.
interface hazard_unit_if #(
   parameter int REG_W   = 5,
   parameter int STAGE_W = 3
);
   logic               id_valid;
   logic [REG_W-1:0]   id_rs;
   logic [REG_W-1:0]   id_rt;
   logic               id_rs_used;
   logic               id_rt_used;
   logic [STAGE_W-1:0] id_rs_need;
   logic [STAGE_W-1:0] id_rt_need;
   logic [REG_W-1:0]   id_dst;
   logic [STAGE_W-1:0] id_ready;
   logic               id_mul_start;
   logic               id_mul_div;
   logic               id_mul_read;
   logic               stall;
   logic [STAGE_W-1:0] fwd_rs;
   logic [STAGE_W-1:0] fwd_rt;
   logic               mul_busy;
   logic [31:0]        stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rs_need,
             id_rt_need, id_dst, id_ready, id_mul_start, id_mul_div, id_mul_read,
      input  stall, fwd_rs, fwd_rt, mul_busy, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rs_need,
             id_rt_need, id_dst, id_ready, id_mul_start, id_mul_div, id_mul_read,
      output stall, fwd_rs, fwd_rt, mul_busy, stall_count
   );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: D-stage interlock and forwarding controller.
// Tracks in-flight writers in stages 1..STAGES-1 plus the mul/div busy
// countdown, and produces stall and the D-stage forwarding selects.
// Optional feature macro: HAZARD_STATS_EN (saturating stall_count statistic);
// when undefined, stall_count is tied to zero and no counter is built.
module hazard_unit #(
   parameter int STAGES     = 4,
   parameter int REG_W      = 5,
   parameter int STAGE_W    = 3,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic          clk,
   input  logic          reset,
   hazard_unit_if.slave  bus
);
   localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // In-flight writer entries, index = stage (1 = E ... STAGES-1 = W)
   logic [STAGES-1:1]  r_vld;
   logic [REG_W-1:0]   r_dst [1:STAGES-1];
   logic [STAGE_W-1:0] r_rdy [1:STAGES-1];
   logic [CNT_W-1:0]   r_cnt;

   logic               w_rs_hit, w_rt_hit;
   logic [STAGE_W-1:0] w_rs_stage, w_rt_stage;
   logic [STAGE_W-1:0] w_rs_rdy, w_rt_rdy;
   logic               w_rs_haz, w_rt_haz, w_mul_haz;
   logic               w_stall, w_busy, w_accept_start;
   logic [STAGE_W-1:0] w_fwd_rs, w_fwd_rt;

   // Youngest-writer search: scan oldest to youngest so the lowest stage wins
   always_comb begin
      w_rs_hit   = 1'b0;
      w_rs_stage = '0;
      w_rs_rdy   = '0;
      w_rt_hit   = 1'b0;
      w_rt_stage = '0;
      w_rt_rdy   = '0;
      for (int s = STAGES - 1; s >= 1; s--) begin
         logic m_rs, m_rt;
         m_rs = r_vld[s] && (r_dst[s] == bus.id_rs) && (bus.id_rs != '0);
         m_rt = r_vld[s] && (r_dst[s] == bus.id_rt) && (bus.id_rt != '0);
         w_rs_hit   = m_rs ? 1'b1 : w_rs_hit;
         w_rs_stage = m_rs ? STAGE_W'(s) : w_rs_stage;
         w_rs_rdy   = m_rs ? r_rdy[s] : w_rs_rdy;
         w_rt_hit   = m_rt ? 1'b1 : w_rt_hit;
         w_rt_stage = m_rt ? STAGE_W'(s) : w_rt_stage;
         w_rt_rdy   = m_rt ? r_rdy[s] : w_rt_rdy;
      end
   end

   // Hazard terms, stall and forwarding selects for the instruction in D
   always_comb begin
      // hazard when the value will not exist by the stage that consumes it
      w_rs_haz = bus.id_rs_used && w_rs_hit &&
                 (({1'b0, w_rs_stage} + {1'b0, bus.id_rs_need}) <= {1'b0, w_rs_rdy});
      w_rt_haz = bus.id_rt_used && w_rt_hit &&
                 (({1'b0, w_rt_stage} + {1'b0, bus.id_rt_need}) <= {1'b0, w_rt_rdy});
      w_busy    = (r_cnt != '0);
      w_mul_haz = bus.id_valid && (bus.id_mul_start || bus.id_mul_read) && w_busy;
      w_stall   = bus.id_valid && (w_rs_haz || w_rt_haz || w_mul_haz);
      w_accept_start = bus.id_valid && bus.id_mul_start && !w_stall;
      w_fwd_rs = (bus.id_rs_used && w_rs_hit && (w_rs_stage > w_rs_rdy)) ? w_rs_stage : '0;
      w_fwd_rt = (bus.id_rt_used && w_rt_hit && (w_rt_stage > w_rt_rdy)) ? w_rt_stage : '0;
   end

   // Outputs are forced quiet while reset is held
   assign bus.stall    = reset ? 1'b0 : w_stall;
   assign bus.fwd_rs   = reset ? '0 : w_fwd_rs;
   assign bus.fwd_rt   = reset ? '0 : w_fwd_rt;
   assign bus.mul_busy = reset ? 1'b0 : w_busy;

   // Writer pipeline: shift toward W; a stalled D injects a bubble into stage 1
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld <= '0;
         for (int s = 1; s < STAGES; s++) begin
            r_dst[s] <= '0;
            r_rdy[s] <= '0;
         end
      end else begin
         for (int s = STAGES - 1; s >= 2; s--) begin
            r_vld[s] <= r_vld[s-1];
            r_dst[s] <= r_dst[s-1];
            r_rdy[s] <= r_rdy[s-1];
         end
         r_vld[1] <= bus.id_valid && !w_stall;
         r_dst[1] <= bus.id_dst;
         r_rdy[1] <= bus.id_ready;
      end
   end

   // Mul/div countdown: reload on an accepted start, otherwise run down to zero
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_accept_start) begin
         r_cnt <= bus.id_mul_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
      end else if (w_busy) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] r_stall_count;

   // Saturating count of stalled cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_count <= 32'd0;
      end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
         r_stall_count <= r_stall_count + 32'd1;
      end else begin
         r_stall_count <= r_stall_count;
      end
   end

   assign bus.stall_count = r_stall_count;
`else
   assign bus.stall_count = 32'd0;
`endif

endmodule
